// File: rtl/pfpu32_pkg.sv
// Shared pfpu32 definitions: rounding modes, integer saturation limits,
// the f2i align-stage record and the rounding-increment decision.
package pfpu32_pkg;

  // FPCSR rounding-mode encodings
  localparam logic [1:0] RM_NEAREST  = 2'b00;
  localparam logic [1:0] RM_ZERO     = 2'b01;
  localparam logic [1:0] RM_PLUSINF  = 2'b10;
  localparam logic [1:0] RM_MINUSINF = 2'b11;

  // Saturation values for a 32-bit signed integer result
  localparam logic [31:0] INT_MAX_POS = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MAX_NEG = 32'h8000_0000;

  // Everything the round stage needs from the align stage
  typedef struct packed {
    logic        sign;
    logic [31:0] mag;
    logic        guard;
    logic        sticky;
    logic        ovf;
    logic        snan;
    logic [1:0]  rmode;
  } f2i_align_t;

  // Whether the truncated magnitude must be bumped by one ulp
  function automatic logic round_inc(input logic [1:0] rmode,
                                     input logic       sign,
                                     input logic       lsb,
                                     input logic       guard,
                                     input logic       sticky);
    logic inc;
    inc = 1'b0;
    case (rmode)
      RM_NEAREST:  inc = guard & (sticky | lsb);
      RM_ZERO:     inc = 1'b0;
      RM_PLUSINF:  inc = ~sign & (guard | sticky);
      RM_MINUSINF: inc = sign & (guard | sticky);
      default:     inc = 1'b0;
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/pfpu32_f2i_rnd_if.sv
// Operand/result bundle between the f2i pre-stage, the round stage and the
// pfpu32 result mux. The round stage is the slave.
interface pfpu32_f2i_rnd_if;

  // operand from the f2i pre-stage
  logic        f2i_rdy_i;
  logic        f2i_sign_i;
  logic [23:0] f2i_int24_i;
  logic [4:0]  f2i_shr_i;
  logic [3:0]  f2i_shl_i;
  logic        f2i_ovf_i;
  logic        f2i_snan_i;

  // result toward the result mux
  logic        f2i_rdy_o;
  logic [31:0] f2i_result_o;
  logic        f2i_ine_o;
  logic        f2i_inv_o;
  logic        f2i_snan_o;

  modport master (
    output f2i_rdy_i, f2i_sign_i, f2i_int24_i, f2i_shr_i, f2i_shl_i,
           f2i_ovf_i, f2i_snan_i,
    input  f2i_rdy_o, f2i_result_o, f2i_ine_o, f2i_inv_o, f2i_snan_o
  );

  modport slave (
    input  f2i_rdy_i, f2i_sign_i, f2i_int24_i, f2i_shr_i, f2i_shl_i,
           f2i_ovf_i, f2i_snan_i,
    output f2i_rdy_o, f2i_result_o, f2i_ine_o, f2i_inv_o, f2i_snan_o
  );

endinterface

// File: rtl/pfpu32_rshift_sticky.sv
// 32-bit logical right shifter that also reports the last bit shifted out
// (guard) and the OR of every bit below it (sticky). A shift of 0 yields
// guard = sticky = 0. Shared with the add/sub align stage.
module pfpu32_rshift_sticky (
  input  logic [31:0] data_i,
  input  logic [4:0]  shr_i,
  output logic [31:0] data_o,
  output logic        guard_o,
  output logic        sticky_o
);

  // Shift into a 64-bit window so the lost bits land in the low half
  logic [63:0] ext;

  assign ext      = {data_i, 32'b0} >> shr_i;
  assign data_o   = ext[63:32];
  assign guard_o  = ext[31];
  assign sticky_o = |ext[30:0];

endmodule

// File: rtl/pfpu32_f2i_rnd.sv
// f2i align/round/saturate stage. S1 aligns the 24-bit integer and captures
// guard/sticky plus the rounding mode; S2 rounds, applies sign and
// saturates. Both stages advance together on adv_i.
module pfpu32_f2i_rnd
  import pfpu32_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic                    adv_i,
  input  logic [1:0]              rmode_i,
  pfpu32_f2i_rnd_if.slave         f2i
);

  // ---------------- S1: align ----------------
  logic [31:0] int32;
  logic [31:0] rs_data;
  logic        rs_guard;
  logic        rs_sticky;

  assign int32 = {8'b0, f2i.f2i_int24_i};

  pfpu32_rshift_sticky u_rshift (
    .data_i   (int32),
    .shr_i    (f2i.f2i_shr_i),
    .data_o   (rs_data),
    .guard_o  (rs_guard),
    .sticky_o (rs_sticky)
  );

  f2i_align_t s1_d, s1_q;
  logic       s1_v_q;

  // Select right- or left-aligned magnitude; left shift drops bits above 31
  always_comb begin
    // NOTE: every field gets a default first so no path can infer a latch.
    s1_d        = '0;
    s1_d.sign   = f2i.f2i_sign_i;
    s1_d.ovf    = f2i.f2i_ovf_i;
    s1_d.snan   = f2i.f2i_snan_i;
    s1_d.rmode  = rmode_i;
    if (f2i.f2i_shr_i != 5'd0) begin
      s1_d.mag    = rs_data;
      s1_d.guard  = rs_guard;
      s1_d.sticky = rs_sticky;
    end else begin
      s1_d.mag    = int32 << f2i.f2i_shl_i;
    end
  end

  // S1 valid bit: reset and flush clear it, otherwise it follows adv_i
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops
    // sample the pre-edge values regardless of block ordering.
    if (rst)          s1_v_q <= 1'b0;
    else if (flush_i) s1_v_q <= 1'b0;
    else if (adv_i)   s1_v_q <= f2i.f2i_rdy_i;
  end

  // S1 datapath capture
  always_ff @(posedge clk) begin
    // NOTE: pure datapath without reset; its contents only matter when the
    // matching valid bit is set, and that bit is reset.
    if (adv_i) s1_q <= s1_d;
  end

  // ---------------- S2: round / saturate ----------------
  logic        inc;
  logic [32:0] mag33;
  logic        ovf_r;
  logic [31:0] result_d;
  logic        ine_d;
  logic        inv_d;

  // Round, detect out-of-range, apply sign and saturate
  always_comb begin
    inc   = round_inc(s1_q.rmode, s1_q.sign, s1_q.mag[0],
                      s1_q.guard, s1_q.sticky);
    mag33 = {1'b0, s1_q.mag} + {32'b0, inc};
    ovf_r = s1_q.ovf
          | (~s1_q.sign & (mag33 > {1'b0, INT_MAX_POS}))
          | ( s1_q.sign & (mag33 > {1'b0, INT_MAX_NEG}));
    if (ovf_r)           result_d = s1_q.sign ? INT_MAX_NEG : INT_MAX_POS;
    else if (s1_q.sign)  result_d = 32'd0 - mag33[31:0];
    else                 result_d = mag33[31:0];
    inv_d = ovf_r | s1_q.snan;
    ine_d = (s1_q.guard | s1_q.sticky) & ~inv_d;
  end

  logic        rdy_q;
  logic [31:0] result_q;
  logic        ine_q;
  logic        inv_q;
  logic        snan_q;

  // Output register: valid and flags zeroed on reset, valid killed on flush
  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_q    <= 1'b0;
      result_q <= 32'd0;
      ine_q    <= 1'b0;
      inv_q    <= 1'b0;
      snan_q   <= 1'b0;
    end else if (flush_i) begin
      rdy_q    <= 1'b0;
    end else if (adv_i) begin
      rdy_q    <= s1_v_q;
      result_q <= result_d;
      ine_q    <= ine_d;
      inv_q    <= inv_d;
      snan_q   <= s1_q.snan;
    end
  end

  assign f2i.f2i_rdy_o    = rdy_q;
  assign f2i.f2i_result_o = result_q;
  assign f2i.f2i_ine_o    = ine_q;
  assign f2i.f2i_inv_o    = inv_q;
  assign f2i.f2i_snan_o   = snan_q;

endmodule
